// File: rtl/perf_counter_sequencer.sv
// Sequences per-section go/stop commands, a global clear and counter snapshots
// onto a single Avalon-MM master port of the performance-counter block.
module perf_counter_sequencer #(
    parameter int READ_LATENCY = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [3:0]  req_go,
    input  logic [3:0]  req_stop,
    input  logic        req_clear,
    input  logic        snap_req,
    input  logic [1:0]  snap_sel,
    output logic [3:0]  m_address,
    output logic        m_write,
    output logic        m_begintransfer,
    output logic [31:0] m_writedata,
    input  logic [31:0] m_readdata,
    output logic        snap_busy,
    output logic        snap_valid,
    output logic [63:0] snap_time,
    output logic [31:0] snap_events,
    output logic [3:0]  ovr
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_WR    = 3'd1;
    localparam logic [2:0] S_RD_LO = 3'd2;
    localparam logic [2:0] S_RD_HI = 3'd3;
    localparam logic [2:0] S_RD_EV = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;

    // Pending command encoding; CMD_CLR only ever appears in wr_kind_q.
    localparam logic [1:0] CMD_NONE = 2'd0;
    localparam logic [1:0] CMD_GO   = 2'd1;
    localparam logic [1:0] CMD_STOP = 2'd2;
    localparam logic [1:0] CMD_CLR  = 2'd3;

    localparam logic [1:0] RD_LAST = 2'(READ_LATENCY);

    logic [2:0]       state_q, state_n;
    logic [3:0][1:0]  pend_q, pend_m, pend_n;
    logic [3:0]       ovr_q, ovr_m, ovr_n;
    logic             clr_q, clr_m, clr_n;
    logic             snap_q, snap_m, snap_n;
    logic [1:0]       snap_sec_q, snap_sec_m;
    logic [1:0]       wr_kind_q, wr_kind_n;
    logic [1:0]       wr_sec_q, wr_sec_n;
    logic [1:0]       rr_q, rr_n;
    logic [1:0]       cnt_q, cnt_n;
    logic [31:0]      time_lo_q, time_hi_q, events_q;
    logic             cap_lo, cap_hi, cap_ev;
    logic             busy;
    logic             found;
    logic [1:0]       gsec, idx;
    logic             snap_acc;

    assign busy = (state_q == S_RD_LO) || (state_q == S_RD_HI) ||
                  (state_q == S_RD_EV) || (state_q == S_DONE);

    // Request merge, round-robin arbitration and next-state logic. Incoming
    // pulses are merged before arbitration so an idle FSM serves them next cycle.
    always_comb begin
        pend_m = pend_q;
        ovr_m  = ovr_q;
        for (int s = 0; s < 4; s++) begin
            if (req_stop[s]) begin
                if (pend_q[s] == CMD_GO) ovr_m[s] = 1'b1;
                pend_m[s] = CMD_STOP;
            end else if (req_go[s]) begin
                if (pend_q[s] == CMD_STOP) ovr_m[s] = 1'b1;
                pend_m[s] = CMD_GO;
            end
        end
        clr_m      = clr_q | req_clear;
        snap_acc   = snap_req & ~snap_q & ~busy;
        snap_m     = snap_q | snap_acc;
        snap_sec_m = snap_acc ? snap_sel : snap_sec_q;

        found = 1'b0;
        gsec  = rr_q;
        idx   = rr_q;
        for (int i = 0; i < 4; i++) begin
            idx = rr_q + 2'(i);
            if (!found && pend_m[idx] != CMD_NONE) begin
                found = 1'b1;
                gsec  = idx;
            end
        end

        state_n   = state_q;
        pend_n    = pend_m;
        ovr_n     = ovr_m;
        clr_n     = clr_m;
        snap_n    = snap_m;
        wr_kind_n = wr_kind_q;
        wr_sec_n  = wr_sec_q;
        rr_n      = rr_q;
        cnt_n     = cnt_q;
        cap_lo    = 1'b0;
        cap_hi    = 1'b0;
        cap_ev    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (clr_m) begin
                    state_n   = S_WR;
                    wr_kind_n = CMD_CLR;
                    wr_sec_n  = 2'd0;
                    clr_n     = 1'b0;
                    pend_n    = '0;
                    ovr_n     = 4'd0;
                end else if (snap_m) begin
                    state_n = S_RD_LO;
                    cnt_n   = 2'd0;
                    snap_n  = 1'b0;
                end else if (found) begin
                    state_n      = S_WR;
                    wr_kind_n    = pend_m[gsec];
                    wr_sec_n     = gsec;
                    pend_n[gsec] = CMD_NONE;
                    rr_n         = gsec + 2'd1;
                end
            end
            S_WR: state_n = S_IDLE;
            S_RD_LO, S_RD_HI, S_RD_EV: begin
                if (cnt_q == RD_LAST) begin
                    cnt_n  = 2'd0;
                    cap_lo = (state_q == S_RD_LO);
                    cap_hi = (state_q == S_RD_HI);
                    cap_ev = (state_q == S_RD_EV);
                    state_n = (state_q == S_RD_LO) ? S_RD_HI :
                              (state_q == S_RD_HI) ? S_RD_EV : S_DONE;
                end else begin
                    cnt_n = cnt_q + 2'd1;
                end
            end
            S_DONE:  state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            pend_q     <= '0;
            ovr_q      <= 4'd0;
            clr_q      <= 1'b0;
            snap_q     <= 1'b0;
            snap_sec_q <= 2'd0;
            wr_kind_q  <= CMD_NONE;
            wr_sec_q   <= 2'd0;
            rr_q       <= 2'd0;
            cnt_q      <= 2'd0;
        end else begin
            state_q    <= state_n;
            pend_q     <= pend_n;
            ovr_q      <= ovr_n;
            clr_q      <= clr_n;
            snap_q     <= snap_n;
            snap_sec_q <= snap_sec_m;
            wr_kind_q  <= wr_kind_n;
            wr_sec_q   <= wr_sec_n;
            rr_q       <= rr_n;
            cnt_q      <= cnt_n;
        end
    end

    // Snapshot results hold until the matching word of the next snapshot lands.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            time_lo_q <= 32'd0;
            time_hi_q <= 32'd0;
            events_q  <= 32'd0;
        end else begin
            if (cap_lo) time_lo_q <= m_readdata;
            if (cap_hi) time_hi_q <= m_readdata;
            if (cap_ev) events_q  <= m_readdata;
        end
    end

    always_comb begin
        m_address       = 4'd0;
        m_write         = 1'b0;
        m_begintransfer = 1'b0;
        m_writedata     = 32'd0;
        case (state_q)
            S_WR: begin
                m_write         = 1'b1;
                m_begintransfer = 1'b1;
                case (wr_kind_q)
                    CMD_CLR:  m_writedata = 32'd1;
                    CMD_STOP: m_address   = {wr_sec_q, 2'b00};
                    CMD_GO:   m_address   = {wr_sec_q, 2'b01};
                    default:  m_address   = 4'd0;
                endcase
            end
            S_RD_LO: m_address = {snap_sec_q, 2'b00};
            S_RD_HI: m_address = {snap_sec_q, 2'b01};
            S_RD_EV: m_address = {snap_sec_q, 2'b10};
            default: m_address = 4'd0;
        endcase
    end

    assign snap_busy   = busy;
    assign snap_valid  = (state_q == S_DONE);
    assign snap_time   = {time_hi_q, time_lo_q};
    assign snap_events = events_q;
    assign ovr         = ovr_q;

endmodule

// File: tb/tb_perf_counter_sequencer.sv
// Scoreboard bench for perf_counter_sequencer: expected bus writes, reads and
// snapshot results are queued with their cycle and matched by a bus monitor.
module tb_perf_counter_sequencer;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic [3:0]  req_go = '0;
    logic [3:0]  req_stop = '0;
    logic        req_clear = 1'b0;
    logic        snap_req = 1'b0;
    logic [1:0]  snap_sel = '0;
    logic [3:0]  m_address;
    logic        m_write;
    logic        m_begintransfer;
    logic [31:0] m_writedata;
    logic [31:0] m_readdata = '0;
    logic        snap_busy;
    logic        snap_valid;
    logic [63:0] snap_time;
    logic [31:0] snap_events;
    logic [3:0]  ovr;

    int cyc = 0;
    int n_checks = 0;
    int n_fail = 0;
    logic [31:0] mem [16];

    typedef struct { logic [3:0] addr; logic [31:0] data; int c; } wr_t;
    typedef struct { logic [3:0] addr; int c; } rd_t;
    typedef struct { logic [63:0] t; logic [31:0] ev; int c; } sn_t;
    wr_t wq[$];
    rd_t rq[$];
    sn_t sq[$];

    perf_counter_sequencer #(.READ_LATENCY(1)) dut (
        .clk(clk), .reset_n(reset_n), .req_go(req_go), .req_stop(req_stop),
        .req_clear(req_clear), .snap_req(snap_req), .snap_sel(snap_sel),
        .m_address(m_address), .m_write(m_write), .m_begintransfer(m_begintransfer),
        .m_writedata(m_writedata), .m_readdata(m_readdata), .snap_busy(snap_busy),
        .snap_valid(snap_valid), .snap_time(snap_time), .snap_events(snap_events),
        .ovr(ovr)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    // Slave with one cycle of read latency.
    always @(posedge clk) m_readdata <= mem[m_address];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic pulse(input logic [3:0] go, input logic [3:0] stop, input logic clr,
                         input logic snap, input logic [1:0] sel);
        req_go = go; req_stop = stop; req_clear = clr; snap_req = snap; snap_sel = sel;
        tick();
        req_go = '0; req_stop = '0; req_clear = 1'b0; snap_req = 1'b0;
    endtask

    task automatic exp_wr(input logic [3:0] a, input logic [31:0] d, input int c);
        wr_t e;
        e.addr = a; e.data = d; e.c = c;
        wq.push_back(e);
    endtask

    task automatic exp_rd(input logic [3:0] a, input int c);
        rd_t e;
        e.addr = a; e.c = c;
        rq.push_back(e);
    endtask

    task automatic exp_sn(input logic [63:0] t, input logic [31:0] ev, input int c);
        sn_t e;
        e.t = t; e.ev = ev; e.c = c;
        sq.push_back(e);
    endtask

    // Bus monitor, sampled on the falling edge.
    always @(negedge clk) begin : mon
        wr_t ew;
        rd_t er;
        sn_t es;
        if (reset_n === 1'b1) begin
            if (m_write) begin
                check("wr_expected", 64'(wq.size() != 0), 64'd1);
                if (wq.size() != 0) begin
                    ew = wq.pop_front();
                    check("wr_addr", 64'(m_address), 64'(ew.addr));
                    check("wr_data", 64'(m_writedata), 64'(ew.data));
                    check("wr_cycle", 64'(cyc), 64'(ew.c));
                    check("wr_ctl", 64'({m_begintransfer, snap_busy}), 64'(2'b10));
                end
            end else if (snap_busy && snap_valid) begin
                check("snap_expected", 64'(sq.size() != 0), 64'd1);
                if (sq.size() != 0) begin
                    es = sq.pop_front();
                    check("snap_time", snap_time, es.t);
                    check("snap_events", 64'(snap_events), 64'(es.ev));
                    check("snap_cycle", 64'(cyc), 64'(es.c));
                end
                check("done_bus", 64'({m_address, m_begintransfer, m_writedata}), 64'd0);
            end else if (snap_busy) begin
                check("rd_expected", 64'(rq.size() != 0), 64'd1);
                if (rq.size() != 0) begin
                    er = rq.pop_front();
                    check("rd_addr", 64'(m_address), 64'(er.addr));
                    check("rd_cycle", 64'(cyc), 64'(er.c));
                end
                check("rd_ctl", 64'({m_begintransfer, m_writedata}), 64'd0);
            end else begin
                check("idle_bus", 64'({m_address, m_begintransfer, m_writedata, snap_valid}), 64'd0);
            end
        end
    end

    initial begin
        int n;
        for (int i = 0; i < 16; i++) mem[i] = 32'h0100_0000 | 32'(i);
        mem[12] = 32'h11; mem[13] = 32'h22; mem[14] = 32'h33;
        mem[4]  = 32'hA5A5_0001; mem[5] = 32'h5A5A_0002; mem[6] = 32'h0000_0BEE;

        #2 reset_n = 1'b0;
        idle(3);
        check("rst_bus", 64'({m_address, m_write, m_begintransfer, m_writedata}), 64'd0);
        check("rst_snapflags", 64'({snap_busy, snap_valid}), 64'd0);
        check("rst_snap_time", snap_time, 64'd0);
        check("rst_snap_events", 64'(snap_events), 64'd0);
        check("rst_ovr", 64'(ovr), 64'd0);
        reset_n = 1'b1;
        idle(2);

        // All four sections at once: round robin from pointer 0, two-cycle spacing.
        n = cyc;
        exp_wr(4'd1, 32'd0, n + 1); exp_wr(4'd5, 32'd0, n + 3);
        exp_wr(4'd9, 32'd0, n + 5); exp_wr(4'd13, 32'd0, n + 7);
        pulse(4'b1111, 4'b0000, 1'b0, 1'b0, 2'd0);
        idle(8);
        n = cyc;
        exp_wr(4'd1, 32'd0, n + 1);
        pulse(4'b0001, 4'b0000, 1'b0, 1'b0, 2'd0);
        idle(3);

        // Single go on section 1.
        n = cyc;
        exp_wr(4'd5, 32'd0, n + 1);
        pulse(4'b0010, 4'b0000, 1'b0, 1'b0, 2'd0);
        idle(4);

        // Simultaneous go+stop keeps stop without flagging overwrite.
        n = cyc;
        exp_wr(4'd8, 32'd0, n + 1);
        pulse(4'b0100, 4'b0100, 1'b0, 1'b0, 2'd0);
        idle(2);
        check("ovr_same_cycle", 64'(ovr), 64'd0);

        // Go while busy, then stop replaces it and sets the overwrite flag.
        n = cyc;
        exp_wr(4'd1, 32'd0, n + 1);
        exp_wr(4'd8, 32'd0, n + 3);
        pulse(4'b0001, 4'b0000, 1'b0, 1'b0, 2'd0);
        pulse(4'b0100, 4'b0000, 1'b0, 1'b0, 2'd0);
        pulse(4'b0000, 4'b0100, 1'b0, 1'b0, 2'd0);
        idle(3);
        check("ovr_replaced", 64'(ovr), 64'(4'b0100));
        n = cyc;
        exp_wr(4'd0, 32'd1, n + 1);
        pulse(4'b0000, 4'b0000, 1'b1, 1'b0, 2'd0);
        idle(2);
        check("ovr_after_clear", 64'(ovr), 64'd0);

        // Snapshot of section 3 with a stop arriving mid-snapshot; second snap_req ignored.
        n = cyc;
        exp_rd(4'd12, n + 1); exp_rd(4'd12, n + 2);
        exp_rd(4'd13, n + 3); exp_rd(4'd13, n + 4);
        exp_rd(4'd14, n + 5); exp_rd(4'd14, n + 6);
        exp_sn(64'h0000_0022_0000_0011, 32'h33, n + 7);
        exp_wr(4'd4, 32'd0, n + 9);
        pulse(4'b0000, 4'b0000, 1'b0, 1'b1, 2'd3);
        idle(1);
        pulse(4'b0000, 4'b0010, 1'b0, 1'b0, 2'd0);
        pulse(4'b0000, 4'b0000, 1'b0, 1'b1, 2'd0);
        idle(8);
        check("snap_time_hold", snap_time, 64'h0000_0022_0000_0011);
        check("snap_events_hold", 64'(snap_events), 64'h33);

        // Clear during a snapshot waits for DONE and discards pending commands.
        n = cyc;
        exp_rd(4'd4, n + 1); exp_rd(4'd4, n + 2);
        exp_rd(4'd5, n + 3); exp_rd(4'd5, n + 4);
        exp_rd(4'd6, n + 5); exp_rd(4'd6, n + 6);
        exp_sn({32'h5A5A_0002, 32'hA5A5_0001}, 32'h0000_0BEE, n + 7);
        exp_wr(4'd0, 32'd1, n + 9);
        pulse(4'b0000, 4'b0000, 1'b0, 1'b1, 2'd1);
        pulse(4'b1000, 4'b0000, 1'b0, 1'b0, 2'd0);
        pulse(4'b0000, 4'b1000, 1'b0, 1'b0, 2'd0);
        pulse(4'b0000, 4'b0000, 1'b1, 1'b0, 2'd0);
        idle(1);
        check("ovr_during_snap", 64'(ovr), 64'(4'b1000));
        idle(8);
        check("ovr_cleared_late", 64'(ovr), 64'd0);

        // Asynchronous reset in RD_HI with a go pending.
        n = cyc;
        exp_rd(4'd8, n + 1); exp_rd(4'd8, n + 2);
        pulse(4'b0000, 4'b0000, 1'b0, 1'b1, 2'd2);
        pulse(4'b0001, 4'b0000, 1'b0, 1'b0, 2'd0);
        idle(1);
        check("rd_hi_addr", 64'(m_address), 64'd9);
        reset_n = 1'b0;
        #1;
        check("arst_bus", 64'({m_address, m_write, m_begintransfer, m_writedata}), 64'd0);
        check("arst_snapflags", 64'({snap_busy, snap_valid}), 64'd0);
        check("arst_snap_time", snap_time, 64'd0);
        check("arst_snap_events", 64'(snap_events), 64'd0);
        idle(2);
        reset_n = 1'b1;
        idle(10);
        check("post_rst_ovr", 64'(ovr), 64'd0);

        check("wq_drained", 64'(wq.size()), 64'd0);
        check("rq_drained", 64'(rq.size()), 64'd0);
        check("sq_drained", 64'(sq.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
